// File: rtl/alu_issue.sv
//------------------------------------------------------------------------------
// alu_issue: sequences narrow (8-bit) and wide (16-bit add) requests through an
// external 8-bit combinational ALU and returns the result over a valid/ready port.
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cmd,
    input  logic             req_wide,
    input  logic [15:0]      req_a,
    input  logic [15:0]      req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_rslt,
    output logic             rsp_flag,
    output logic [CNT_W-1:0] rsp_count,
    output logic [3:0]       alu_cmd,
    output logic [7:0]       alu_inA,
    output logic [7:0]       alu_inB,
    input  logic [7:0]       alu_rslt,
    input  logic             alu_out
);

    localparam logic [3:0] C_CMD_ADD = 4'b0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        INC  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t           state_q;
    logic             wide_q;
    logic [7:0]       a_hi_q;
    logic [7:0]       b_hi_q;
    logic             lo_c_q;
    logic             hi_c_q;
    logic [15:0]      rslt_q;
    logic             flag_q;
    logic             valid_q;
    logic             ready_q;
    logic [CNT_W-1:0] count_q;
    logic [3:0]       alu_cmd_q;
    logic [7:0]       alu_a_q;
    logic [7:0]       alu_b_q;

    // ALU drive registers are loaded on the edge entering LO/HI/INC so that the
    // operands are valid for the whole cycle spent in that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wide_q    <= 1'b0;
            a_hi_q    <= 8'h00;
            b_hi_q    <= 8'h00;
            lo_c_q    <= 1'b0;
            hi_c_q    <= 1'b0;
            rslt_q    <= 16'h0000;
            flag_q    <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            count_q   <= '0;
            alu_cmd_q <= 4'h0;
            alu_a_q   <= 8'h00;
            alu_b_q   <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q   <= LO;
                        ready_q   <= 1'b0;
                        wide_q    <= req_wide && (req_cmd == C_CMD_ADD);
                        a_hi_q    <= req_a[15:8];
                        b_hi_q    <= req_b[15:8];
                        rslt_q    <= 16'h0000;
                        alu_cmd_q <= req_cmd;
                        alu_a_q   <= req_a[7:0];
                        alu_b_q   <= req_b[7:0];
                    end
                end
                LO: begin
                    rslt_q[7:0] <= alu_rslt;
                    lo_c_q      <= alu_out;
                    alu_cmd_q   <= C_CMD_ADD;
                    if (wide_q) begin
                        state_q <= HI;
                        alu_a_q <= a_hi_q;
                        alu_b_q <= b_hi_q;
                    end else begin
                        state_q <= RESP;
                        flag_q  <= alu_out;
                        valid_q <= 1'b1;
                        alu_a_q <= 8'h00;
                        alu_b_q <= 8'h00;
                    end
                end
                HI: begin
                    rslt_q[15:8] <= alu_rslt;
                    hi_c_q       <= alu_out;
                    if (lo_c_q) begin
                        // Propagate the low-byte carry with a second add of 1.
                        state_q <= INC;
                        alu_a_q <= alu_rslt;
                        alu_b_q <= 8'h01;
                    end else begin
                        state_q <= RESP;
                        flag_q  <= alu_out;
                        valid_q <= 1'b1;
                        alu_a_q <= 8'h00;
                        alu_b_q <= 8'h00;
                    end
                end
                INC: begin
                    rslt_q[15:8] <= alu_rslt;
                    flag_q       <= hi_c_q | alu_out;
                    state_q      <= RESP;
                    valid_q      <= 1'b1;
                    alu_a_q      <= 8'h00;
                    alu_b_q      <= 8'h00;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        count_q <= count_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    valid_q   <= 1'b0;
                    ready_q   <= 1'b1;
                    alu_cmd_q <= 4'h0;
                    alu_a_q   <= 8'h00;
                    alu_b_q   <= 8'h00;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rslt  = rslt_q;
    assign rsp_flag  = flag_q;
    assign rsp_count = count_q;
    assign alu_cmd   = alu_cmd_q;
    assign alu_inA   = alu_a_q;
    assign alu_inB   = alu_b_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
//------------------------------------------------------------------------------
// tb_alu_issue: directed vectors against alu_issue with a behavioural 8-bit ALU.
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue;

    localparam int CNT_W = 4;

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b0001;
    localparam logic [3:0] C_CMP  = 4'b0011;
    localparam logic [3:0] C_MOVL = 4'b0100;
    localparam logic [3:0] C_MOVR = 4'b0101;
    localparam logic [3:0] C_AND  = 4'b0110;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_cmd = 4'h0;
    logic             req_wide = 1'b0;
    logic [15:0]      req_a = 16'h0;
    logic [15:0]      req_b = 16'h0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [15:0]      rsp_rslt;
    logic             rsp_flag;
    logic [CNT_W-1:0] rsp_count;
    logic [3:0]       alu_cmd;
    logic [7:0]       alu_inA;
    logic [7:0]       alu_inB;
    logic [7:0]       alu_rslt;
    logic             alu_out;

    int               n_vec = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_count = '0;

    always #5 clk = ~clk;

    alu_issue #(.CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_wide  (req_wide),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rslt  (rsp_rslt),
        .rsp_flag  (rsp_flag),
        .rsp_count (rsp_count),
        .alu_cmd   (alu_cmd),
        .alu_inA   (alu_inA),
        .alu_inB   (alu_inB),
        .alu_rslt  (alu_rslt),
        .alu_out   (alu_out)
    );

    // Reference ALU: MOVR passes A, MOVL passes B, CMP flags equality.
    always_comb begin
        alu_rslt = 8'h00;
        alu_out  = 1'b0;
        case (alu_cmd)
            C_ADD:   {alu_out, alu_rslt} = {1'b0, alu_inA} + {1'b0, alu_inB};
            C_SUB:   {alu_out, alu_rslt} = {1'b0, alu_inA} - {1'b0, alu_inB};
            C_CMP:   alu_out  = (alu_inA == alu_inB);
            C_MOVL:  alu_rslt = alu_inB;
            C_MOVR:  alu_rslt = alu_inA;
            C_AND:   alu_rslt = alu_inA & alu_inB;
            default: alu_rslt = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request with rsp_ready held high, check latency, result, flag, count.
    task automatic run_op(input string tag, input logic [3:0] cmd, input logic wide,
                          input logic [15:0] a, input logic [15:0] b, input int exp_lat,
                          input logic [15:0] exp_rslt, input logic exp_flag);
        int lat;
        chk({tag, ".ready"}, req_ready, 1'b1);
        req_cmd = cmd; req_wide = wide; req_a = a; req_b = b; req_valid = 1'b1;
        step();
        req_valid = 1'b0; req_cmd = 4'hF; req_a = 16'hDEAD; req_b = 16'hBEEF;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            step();
            lat++;
        end
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".rslt"}, rsp_rslt, exp_rslt);
        chk({tag, ".flag"}, rsp_flag, exp_flag);
        chk({tag, ".alu0"}, {alu_cmd, alu_inA, alu_inB}, 20'h0);
        step();
        exp_count = exp_count + 1'b1;
        chk({tag, ".cnt"}, rsp_count, exp_count);
    endtask

    initial begin
        logic [15:0] held;

        // Reset state
        #1;
        chk("rst.valid", rsp_valid, 1'b0);
        chk("rst.out", {rsp_rslt, rsp_flag, rsp_count}, 0);
        chk("rst.alu", {alu_cmd, alu_inA, alu_inB}, 20'h0);
        step();
        reset = 1'b0;
        step();
        chk("rst.ready", req_ready, 1'b1);

        // Reset during the HI pass of a wide add discards the operation
        run_op("pre", C_ADD, 1'b0, 16'd3, 16'd4, 1, 16'd7, 1'b0);
        req_cmd = C_ADD; req_wide = 1'b1; req_a = 16'h1234; req_b = 16'h0101; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("lo.drv", {alu_cmd, alu_inA, alu_inB}, {4'h0, 8'h34, 8'h01});
        step();
        chk("hi.drv", {alu_cmd, alu_inA, alu_inB}, {4'h0, 8'h12, 8'h01});
        reset = 1'b1;
        #1;
        chk("midrst.valid", rsp_valid, 1'b0);
        chk("midrst.cnt", rsp_count, 0);
        chk("midrst.alu", {alu_cmd, alu_inA, alu_inB}, 20'h0);
        exp_count = '0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst.norsp", rsp_valid, 1'b0);
        end
        run_op("add1+1", C_ADD, 1'b0, 16'd1, 16'd1, 1, 16'd2, 1'b0);

        // Narrow operations
        run_op("add18+49", C_ADD, 1'b0, 16'd18, 16'd49, 1, 16'd67, 1'b0);
        run_op("add255+255", C_ADD, 1'b0, 16'd255, 16'd255, 1, 16'd254, 1'b1);
        run_op("cmp.eq", C_CMP, 1'b0, 16'd27, 16'd27, 1, 16'd0, 1'b1);
        run_op("cmp.ne", C_CMP, 1'b0, 16'd27, 16'd26, 1, 16'd0, 1'b0);
        run_op("movr", C_MOVR, 1'b0, 16'd24, 16'd26, 1, 16'd24, 1'b0);
        run_op("movl", C_MOVL, 1'b0, 16'h7724, 16'h661A, 1, 16'h001A, 1'b0);
        run_op("and", C_AND, 1'b0, 16'h00F0, 16'h003C, 1, 16'h0030, 1'b0);
        run_op("subwide", C_SUB, 1'b1, 16'h550A, 16'h3303, 1, 16'h0007, 1'b0);
        run_op("sub.brw", C_SUB, 1'b0, 16'd3, 16'd5, 1, 16'h00FE, 1'b1);

        // Wide adds
        run_op("w01FF", C_ADD, 1'b1, 16'h01FF, 16'h0001, 3, 16'h0200, 1'b0);
        run_op("w1234", C_ADD, 1'b1, 16'h1234, 16'h0101, 2, 16'h1335, 1'b0);
        run_op("wFFFF", C_ADD, 1'b1, 16'hFFFF, 16'h0001, 3, 16'h0000, 1'b1);
        run_op("wFF00", C_ADD, 1'b1, 16'hFF00, 16'h0100, 2, 16'h0000, 1'b1);

        // Backpressure: response held, new requests ignored
        rsp_ready = 1'b0;
        req_cmd = C_ADD; req_wide = 1'b0; req_a = 16'd100; req_b = 16'd50; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("bp.valid", rsp_valid, 1'b1);
        held = rsp_rslt;
        chk("bp.rslt0", held, 16'd150);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_a = 16'd9; req_b = 16'd9;
            step();
            chk("bp.stable", {rsp_valid, rsp_rslt, rsp_flag}, {1'b1, 16'd150, 1'b0});
            chk("bp.ready", req_ready, 1'b0);
            chk("bp.cnt", rsp_count, exp_count);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        exp_count = exp_count + 1'b1;
        chk("bp.cnt+1", rsp_count, exp_count);
        chk("bp.ready1", req_ready, 1'b1);
        chk("bp.idle", rsp_valid, 1'b0);
        step();
        chk("bp.noaccept", rsp_valid, 1'b0);

        // Drive the counter through its wrap
        while (exp_count != '0) begin
            run_op("wrap", C_ADD, 1'b0, 16'd5, 16'd6, 1, 16'd11, 1'b0);
        end
        chk("wrap.zero", rsp_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter CNT_W, default 8, width of the completed-response counter.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_cmd  input  4  ALU command (0000 ADD, 0001 SUB, 0011 CMP, 0100 MOVL, 0101 MOVR, 0110 AND, etc.).
REQ-008 req_wide  input  1  16-bit add request; honored only when req_cmd=0000.
REQ-009 req_a, req_b  input  16 each  operands; narrow ops use bits [7:0] only.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  consumer accepts response.
REQ-012 rsp_rslt  output  16  result; bits [15:8] are 0 for narrow ops.
REQ-013 rsp_flag  output  1  ALU flag (carry for ADD/wide ADD, equal for CMP).
REQ-014 rsp_count  output  CNT_W  number of completed response handshakes.
REQ-015 alu_cmd  output  4,  alu_inA / alu_inB  output  8 each  drive the ALU.
REQ-016 alu_rslt  input  8,  alu_out  input  1  combinational ALU result and flag.

Function
REQ-017 FSM states SHALL be IDLE, LO, HI, INC, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; request accepted on a rising edge with req_valid & req_ready, latching cmd, wide, a, b.
REQ-019 Accept edge: IDLE -> LO.
REQ-020 LO: drive alu_cmd=latched cmd, alu_inA=a[7:0], alu_inB=b[7:0]; at the next edge capture alu_rslt into rslt[7:0] and alu_out into low-carry; go to HI if wide, else RESP with flag=alu_out.
REQ-021 HI: drive 0000, a[15:8], b[15:8]; at the next edge capture rslt[15:8] and hi-carry; go to INC if low-carry=1, else RESP with flag=hi-carry.
REQ-022 INC: drive 0000, rslt[15:8], 8'h01; at the next edge rslt[15:8] <= alu_rslt and flag <= hi-carry | alu_out; go to RESP.
REQ-023 Latency from accept edge to rsp_valid high: narrow 1 edge; wide 2 edges without low carry, 3 edges with low carry.
REQ-024 RESP: rsp_valid=1; rsp_rslt and rsp_flag SHALL stay stable while rsp_ready=0.
REQ-025 Edge with rsp_valid & rsp_ready: go to IDLE and increment rsp_count, which wraps from all-ones to 0.
REQ-026 Back-to-back throughput: no new request is accepted in the RESP handshake cycle; req_ready rises the cycle after that handshake.
REQ-027 In IDLE and RESP, alu_cmd, alu_inA and alu_inB SHALL be 0.
REQ-028 req_wide=1 with req_cmd!=0000 SHALL be processed as a narrow op, rsp_rslt[15:8]=0.
REQ-029 Inputs on req_* outside an accept edge SHALL be ignored.

Reset
REQ-030 On reset assertion, immediately: state IDLE, rsp_valid=0, rsp_rslt=0, rsp_flag=0, rsp_count=0, alu_* outputs=0; req_ready=1 after reset deasserts.
REQ-031 Reset in any state, including mid-wide-operation, SHALL discard the pending operation with no response.

Verification
REQ-032 Narrow ADD a=18 b=49 -> 1 edge after accept: rsp_rslt=67, flag=0; then a=255 b=255 -> rslt=254, flag=1.
REQ-033 CMP a=27 b=27 -> flag=1, rslt=0; CMP a=27 b=26 -> flag=0; MOVR a=24 b=26 -> rslt=24.
REQ-034 Wide ADD 0x01FF+0x0001 -> passes LO/HI/INC, rsp_valid 3 edges after accept: rslt=0x0200, flag=0; 0x1234+0x0101 -> 2 edges: rslt=0x1335, flag=0.
REQ-035 Wide ADD 0xFFFF+0x0001 -> rslt=0x0000, flag=1; 0xFF00+0x0100 -> rslt=0x0000, flag=1 with no INC pass.
REQ-036 Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp outputs stable, req_ready=0, req_valid ignored; release -> rsp_count +1, req_ready=1 the following cycle.
REQ-037 Assert reset during HI of a wide op -> rsp_valid=0 and rsp_count=0 immediately; no response follows; next narrow ADD 1+1 -> rslt=2.
